// File: rtl/commit_buffer_pkg.sv
// Shared types for the in-order commit buffer.
// Contents: u8/w32 aliases, entry kind, branch outcome, completion message
// (Result), retirement message (CommitEntry) and the per-entry payload held
// in the buffer RAM, plus a helper that turns a stored entry into a commit
// message.
package commit_buffer_pkg;

    typedef logic [7:0]  u8;
    typedef logic [31:0] w32;

    typedef enum logic {
        KIND_WB     = 1'b0,
        KIND_BRANCH = 1'b1
    } kind_e;

    typedef struct packed {
        logic miss;
        w32   target;
    } branch_result_t;

    // Completion content; a wb result uses wb_data, a branch result uses branch.
    typedef struct packed {
        w32             wb_data;
        branch_result_t branch;
    } result_data_t;

    typedef struct packed {
        u8            commit_id;
        kind_e        kind;
        result_data_t data;
    } result_t;

    typedef struct packed {
        kind_e        kind;
        logic         notify_only;
        logic [1:0]   notify;
        u8            dest_logic;
        result_data_t data;
    } commit_entry_t;

    // Payload stored per buffer slot; notify_only is derived on the way out.
    typedef struct packed {
        kind_e        kind;
        logic [1:0]   notify;
        u8            dest_logic;
        result_data_t data;
    } entry_t;

    function automatic commit_entry_t entry_to_commit(entry_t e);
        commit_entry_t c;
        c.kind        = e.kind;
        c.notify_only = (e.notify != 2'b00);
        c.notify      = e.notify;
        c.dest_logic  = e.dest_logic;
        c.data        = e.data;
        return c;
    endfunction

endpackage

// File: rtl/commit_buffer_chk.sv
// Protocol checker for the commit buffer completion ports.
// Flags results aimed at free slots, results whose kind differs from the
// allocated kind, and two ports hitting the same slot in one cycle.
module commit_buffer_chk
    import commit_buffer_pkg::*;
#(
    parameter  int DEPTH    = 64,
    parameter  int N_RESULT = 4,
    localparam int PTR_W    = $clog2(DEPTH)
) (
    input logic                        clk,
    input logic                        reset,
    input logic [N_RESULT-1:0]         result_en,
    input result_t [N_RESULT-1:0]      result_msg,
    input logic [DEPTH-1:0]            alloc_vec,
    input logic [DEPTH-1:0]            kind_vec
);

    // Per-edge completion-port legality checks.
    always @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < N_RESULT; i++) begin
                if (result_en[i]) begin
                    assert (alloc_vec[result_msg[i].commit_id[PTR_W-1:0]])
                        else $error("commit_buffer: result on port %0d for free id %0d",
                                    i, result_msg[i].commit_id);
                    assert (!alloc_vec[result_msg[i].commit_id[PTR_W-1:0]] ||
                            (result_msg[i].kind == kind_e'(kind_vec[result_msg[i].commit_id[PTR_W-1:0]])))
                        else $error("commit_buffer: result kind differs on port %0d", i);
                    for (int j = i + 1; j < N_RESULT; j++) begin
                        assert (!(result_en[j] &&
                                  (result_msg[j].commit_id[PTR_W-1:0] == result_msg[i].commit_id[PTR_W-1:0])))
                            else $error("commit_buffer: ports %0d and %0d hit the same id", i, j);
                    end
                end
            end
        end
    end

endmodule

// File: rtl/commit_buffer_ram.sv
// Payload storage for the commit buffer: DEPTH slots of entry_t.
// Ports: one allocation write port (whole entry), N_RESULT completion write
// ports (data field only, so the allocated kind/dest are never overwritten),
// one asynchronous read port addressed by the head index.
module commit_buffer_ram
    import commit_buffer_pkg::*;
#(
    parameter  int DEPTH    = 64,
    parameter  int N_RESULT = 4,
    localparam int PTR_W    = $clog2(DEPTH)
) (
    input  logic                               clk,
    input  logic                               alloc_we_i,
    input  logic [PTR_W-1:0]                   alloc_addr_i,
    input  entry_t                             alloc_data_i,
    input  logic [N_RESULT-1:0]                res_we_i,
    input  logic [N_RESULT-1:0][PTR_W-1:0]     res_addr_i,
    input  result_data_t [N_RESULT-1:0]        res_data_i,
    input  logic [PTR_W-1:0]                   rd_addr_i,
    output entry_t                             rd_data_o
);

    entry_t mem_q [DEPTH];

    // Slot writes; later completion ports override earlier ones on the same slot.
    always_ff @(posedge clk) begin
        if (alloc_we_i) begin
            mem_q[alloc_addr_i] <= alloc_data_i;
        end
        for (int i = 0; i < N_RESULT; i++) begin
            if (res_we_i[i]) begin
                mem_q[res_addr_i[i]].data <= res_data_i[i];
            end
        end
    end

    assign rd_data_o = mem_q[rd_addr_i];

endmodule

// File: rtl/commit_buffer.sv
// In-order commit (reorder) buffer.
// Ports: alloc_* (allocation handshake, returns alloc_id), result_* (N_RESULT
// completion ports, never back-pressured), commit_* (in-order retirement
// handshake), flush (one-cycle pulse after a mispredicted branch retires),
// count (occupancy). clk/reset: synchronous active-high reset.
module commit_buffer
    import commit_buffer_pkg::*;
#(
    parameter  int DEPTH    = 64,
    parameter  int N_RESULT = 4,
    localparam int PTR_W    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   alloc_en,
    input  logic                   alloc_kind,
    input  logic [1:0]             alloc_notify,
    input  logic [7:0]             alloc_dest_logic,
    output logic                   alloc_reject,
    output logic [7:0]             alloc_id,
    input  logic [N_RESULT-1:0]    result_en,
    input  result_t [N_RESULT-1:0] result_msg,
    output logic [N_RESULT-1:0]    result_reject,
    output logic                   commit_en,
    output commit_entry_t          commit_msg,
    input  logic                   commit_reject,
    output logic                   flush,
    output logic [PTR_W:0]         count
);

    localparam logic [PTR_W:0] PTR_ONE = (PTR_W+1)'(1);

    logic [PTR_W:0]             head_q, head_d, tail_q, tail_d;
    logic [DEPTH-1:0]           alloc_q, alloc_d, done_q, done_d, kind_q, kind_d;
    logic                       flush_q, flush_d;
    logic [PTR_W-1:0]           head_idx_s, tail_idx_s;
    logic [PTR_W:0]             count_s;
    logic                       full_s, empty_s, commit_en_s, pop_s, trigger_s, alloc_acc_s;
    logic [N_RESULT-1:0]        res_we_s;
    logic [N_RESULT-1:0][PTR_W-1:0] res_idx_s;
    result_data_t [N_RESULT-1:0] res_data_s;
    entry_t                     head_entry_s, alloc_entry_s;

    assign head_idx_s = head_q[PTR_W-1:0];
    assign tail_idx_s = tail_q[PTR_W-1:0];
    assign count_s    = tail_q - head_q;
    assign full_s     = (count_s == (PTR_W+1)'(DEPTH));
    assign empty_s    = (count_s == {(PTR_W+1){1'b0}});
    assign commit_en_s = ~empty_s & done_q[head_idx_s];

    // Retirement handshake and misprediction trigger.
    always_comb begin
        pop_s     = commit_en_s & ~commit_reject;
        trigger_s = pop_s & (head_entry_s.kind == KIND_BRANCH) & head_entry_s.data.branch.miss;
        // A wrong-path allocation in the trigger cycle is dropped without consuming its id.
        alloc_acc_s = alloc_en & ~full_s & ~trigger_s;
    end

    // Completion port decode; results to free slots or during a flush trigger are dropped.
    always_comb begin
        for (int i = 0; i < N_RESULT; i++) begin
            res_idx_s[i]  = result_msg[i].commit_id[PTR_W-1:0];
            res_data_s[i] = result_msg[i].data;
            res_we_s[i]   = result_en[i] & alloc_q[result_msg[i].commit_id[PTR_W-1:0]] & ~trigger_s;
        end
    end

    // New slot contents: allocation clears any stale completion data.
    always_comb begin
        alloc_entry_s.kind       = kind_e'(alloc_kind);
        alloc_entry_s.notify     = alloc_notify;
        alloc_entry_s.dest_logic = alloc_dest_logic;
        alloc_entry_s.data       = '0;
    end

    // Next-state for pointers and per-slot status bits.
    always_comb begin
        alloc_d = alloc_q;
        done_d  = done_q;
        kind_d  = kind_q;
        head_d  = head_q;
        tail_d  = tail_q;
        flush_d = trigger_s;
        if (trigger_s) begin
            // Everything younger than the mispredicted branch is squashed.
            alloc_d = {DEPTH{1'b0}};
            done_d  = {DEPTH{1'b0}};
            head_d  = head_q + PTR_ONE;
            tail_d  = head_q + PTR_ONE;
        end else begin
            for (int i = 0; i < N_RESULT; i++) begin
                done_d[res_idx_s[i]] = done_d[res_idx_s[i]] | res_we_s[i];
            end
            if (alloc_acc_s) begin
                alloc_d[tail_idx_s] = 1'b1;
                done_d[tail_idx_s]  = (alloc_notify != 2'b00);
                kind_d[tail_idx_s]  = alloc_kind;
                tail_d              = tail_q + PTR_ONE;
            end else begin
                tail_d = tail_q;
            end
            // Pop is applied last so a retiring slot always ends up free.
            if (pop_s) begin
                alloc_d[head_idx_s] = 1'b0;
                done_d[head_idx_s]  = 1'b0;
                head_d              = head_q + PTR_ONE;
            end else begin
                head_d = head_q;
            end
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= {(PTR_W+1){1'b0}};
            tail_q  <= {(PTR_W+1){1'b0}};
            alloc_q <= {DEPTH{1'b0}};
            done_q  <= {DEPTH{1'b0}};
            kind_q  <= {DEPTH{1'b0}};
            flush_q <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            alloc_q <= alloc_d;
            done_q  <= done_d;
            kind_q  <= kind_d;
            flush_q <= flush_d;
        end
    end

    commit_buffer_ram #(.DEPTH(DEPTH), .N_RESULT(N_RESULT)) u_ram (
        .clk          (clk),
        .alloc_we_i   (alloc_acc_s),
        .alloc_addr_i (tail_idx_s),
        .alloc_data_i (alloc_entry_s),
        .res_we_i     (res_we_s),
        .res_addr_i   (res_idx_s),
        .res_data_i   (res_data_s),
        .rd_addr_i    (head_idx_s),
        .rd_data_o    (head_entry_s)
    );

    commit_buffer_chk #(.DEPTH(DEPTH), .N_RESULT(N_RESULT)) u_chk (
        .clk        (clk),
        .reset      (reset),
        .result_en  (result_en),
        .result_msg (result_msg),
        .alloc_vec  (alloc_q),
        .kind_vec   (kind_q)
    );

    // Commit message is forced to zero whenever nothing retires.
    always_comb begin
        if (commit_en_s) begin
            commit_msg = entry_to_commit(head_entry_s);
        end else begin
            commit_msg = '0;
        end
    end

    assign commit_en     = commit_en_s;
    assign alloc_reject  = full_s;
    assign alloc_id      = 8'(tail_idx_s);
    assign result_reject = {N_RESULT{1'b0}};
    assign flush         = flush_q;
    assign count         = count_s;

endmodule

// File: doc/commit_buffer.md
Name: commit_buffer

Overview:
Parametrised in-order commit (reorder) buffer for the out-of-order core. Decode allocates one entry per instruction and receives its commit_id. Execution units post Result messages on N independent completion ports, in any order. Entries retire strictly in program order toward the register file/PC logic, and a mispredicted branch at retirement flushes all younger entries.

Parameters:
DEPTH, 64, number of entries; power of two, 2..256 (commit_id is u8)
N_RESULT, 4, number of completion ports (ALU, FPU, MEM, UART/branch)
PTR_W, $clog2(DEPTH), index width; derived, not overridable

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high
alloc_en  in  1  allocation request (sender side of en/reject handshake)
alloc_kind  in  1  0: wb, 1: branch
alloc_notify  in  2  nonzero = notify-only entry; [0] uart, [1] sw
alloc_dest_logic  in  8  logical destination, echoed at commit
alloc_reject  out  1  buffer full; request not taken
alloc_id  out  8  commit_id given to the current request (valid when alloc_en & ~alloc_reject)
result_en  in  N_RESULT  per-port completion valid
result_msg  in  N_RESULT x Result  packed Result (commit_id, kind, wb/branch content)
result_reject  out  N_RESULT  tied 0; ports never back-pressured
commit_en  out  1  head entry retiring
commit_msg  out  CommitEntry  kind, notify_only, notify, dest_logic, data or BranchResult
commit_reject  in  1  consumer stall
flush  out  1  one-cycle pulse; misprediction retired
count  out  PTR_W+1  occupied entries (debug/perf)

Behaviour:
- Handshake: a transfer occurs when en & ~reject in the same cycle. The sender holds en and msg stable while rejected.
- State: head and tail pointers (PTR_W+1 bits, wrap modulo 2*DEPTH); per entry: alloc bit, done bit, and a payload.
- count = tail - head; full = count == DEPTH; empty = count == 0.
- Reset: head = tail = 0, all alloc/done bits cleared. Outputs: alloc_reject=0, commit_en=0, flush=0, count=0, commit_msg=0.
- Allocation:
  - alloc_reject = full, computed from registered state only. There is no bypass from a pop in the same cycle, so a full buffer rejects even while it commits.
  - alloc_id = tail[PTR_W-1:0], zero-extended to 8 bits.
  - An accepted allocation writes the entry, sets alloc=1, and increments tail.
  - Notify-only entries (alloc_notify != 0) are written with done=1 at allocation; they need no result.
- Completion:
  - result_en[i] writes the payload at index result_msg[i].commit_id[PTR_W-1:0] and sets done=1.
  - A write takes effect at the clock edge. Minimum result-to-commit latency is 1 cycle.
  - A result aimed at an entry with alloc=0 is dropped; the simulation assertion fires.
  - Two ports hitting the same id in one cycle is illegal (assertion). If it happens, the highest port index wins.
  - A result kind that mismatches the allocated kind is an assertion error; the allocated kind is kept.
- Commit:
  - commit_en = ~empty & done[head]. It depends only on registered state, with no combinational path from any input.
  - commit_msg is the head entry's payload. notify_only = (notify != 0).
  - Pop when commit_en & ~commit_reject: clear alloc and done at head, then head++. At most one pop per cycle.
- Flush:
  - Trigger: a popped entry with kind=branch and branch.miss=1.
  - At that edge, clear every alloc and done bit and set tail = head+1 (the new head), so count becomes 0.
  - flush is registered and asserts for exactly the next cycle.
  - An allocation accepted in the trigger cycle is discarded (wrong path), and its id is not consumed.
  - Results arriving in the trigger cycle are discarded.
  - Results arriving while flush=1 target freed entries and are therefore dropped by the alloc=0 rule.
- Wrap: ids repeat modulo DEPTH. Uniqueness is guaranteed by the full check.
- Simultaneous events:
  - Allocate and pop in the same cycle: count unchanged.
  - A result for the head in the same cycle as commit_reject=1: the entry stays, and the data is visible next cycle.
- Reset mid-operation: all state clears in one cycle; nothing is committed afterward.

Decomposition:
- Shared package (bus/typedefs): Result, CommitEntry, BranchResult, the u8/w32 aliases, and the Message interface for the alloc and commit ports.
- Local: the entry payload struct.
- Sub-module commit_buffer_ram: DEPTH x payload, N_RESULT+1 write ports (alloc + results), one async read port at head.
- The top level keeps the pointers, alloc/done bit vectors and flush logic.

Test Plan:
- Reset, then allocate 3 wb entries → alloc_id 0,1,2. Results for ids 2,0,1 on ports 3,0,1 → commits in order 0,1,2 with matching data; count returns to 0.
- DEPTH=4: allocate 4 entries → alloc_reject=1 on the 5th while count=4. Complete and commit id 0 while alloc_en is held → 5th accepted the cycle after the pop, alloc_id=0 (wrap).
- Allocate a notify-only sw entry (notify=2'b10) → commit_en the next cycle with no result, notify_only=1.
- Branch at id 1 with miss=1 and ids 2..5 completed; commit id 1 → flush=1 for one cycle, count=0. An allocation made in the trigger cycle is absent. The next allocation returns id 2.
- Hold commit_reject=1 for 5 cycles with the head done → commit_en stays 1 and commit_msg stays stable; no pop, no flush.
- Apply reset mid-stream with 6 entries pending → next cycle count=0, commit_en=0; a late result for an old id is dropped (assertion, no commit).
